hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Second-generation pipeline hazard controller for the 5-stage MIPS core. It replaces the purely combinational hazard unit and adds three stateful features:
- a multi-cycle MDU occupancy counter that holds the divide/multiply in E;
- an exception-flush FSM that defers an M-stage exception until memory stalls release;
- a saturating stall-cycle performance counter.

Forwarding selects and per-stage stall/flush controls go directly to the datapath pipeline registers.

## Interface
Parameters:
- REG_W, 5, register-address width
- MDU_LAT, 32, cycles an MDU op occupies E; must be ≥1 (1 means no stall)
- CNT_W, 32, perf-counter width

Ports:
- clk  in  1  core clock
- resetn  in  1  asynchronous, active-low reset
- rsD, rtD  in  REG_W  D-stage sources
- branchD, jumprD  in  1  D-stage branch / jr-jalr
- rsE, rtE, writeregE  in  REG_W  E-stage sources / destination
- regwrite_enE, branchE, predict_wrong  in  1  E-stage controls
- memtoregE, memtoregM  in  2  load selects; nonzero = load
- mdu_start_E  in  1  E holds an MDU op
- writeregM, writeregW  in  REG_W  destinations
- regwrite_enM, regwrite_enW  in  1  write enables
- exc_M  in  1  exception detected in M
- i_stall, d_stall  in  1  memory interface stalls
- perf_clr  in  1  synchronous clear of the stall counter
- forwardaD, forwardbD  out  1  M→D forward
- forwardaE, forwardbE  out  2  10 = M, 01 = W, 00 = register file
- stallF, stallD, stallE, stallM, stallW  out  1
- flushF, flushD, flushE, flushM, flushW  out  1
- longest_stall  out  1  mem_stall | mdu_busy
- mdu_done  out  1  MDU result valid in E this cycle
- exc_redirect  out  1  one-cycle PC redirect to the exception vector
- stall_cycles  out  CNT_W  saturating count of stallF cycles

## Operation
Forwarding:
- Same rules as generation 1; register 0 is never forwarded.
- M has priority over W.

Hazard terms:
- mem_stall = i_stall | d_stall.
- lw = (memtoregE≠0) & (rtE==rsD | rtE==rtD).
- jr = jumprD & regwrite_enE & (writeregE==rsD | writeregE==rtD).
- br = branchD & ((regwrite_enE & writeregE∈{rsD,rtD}) | ((memtoregM≠0) & writeregM∈{rsD,rtD})).
- hz = lw | jr | br.

MDU counter (cnt, 0..MDU_LAT-1):
- mdu_busy = mdu_start_E & (cnt≠MDU_LAT-1).
- mdu_done = mdu_start_E & (cnt==MDU_LAT-1).
- cnt advances only when mdu_start_E & ~mem_stall & ~exc_flush.
  - At MDU_LAT-1 it wraps to 0; otherwise it increments.
- exc_flush forces cnt to 0.
- mem_stall freezes cnt.

Exception FSM (states RUN, EXC_WAIT):
- RUN:
  - exc_M & ~mem_stall → exc_flush this cycle; stay in RUN.
  - exc_M & mem_stall → EXC_WAIT.
- EXC_WAIT:
  - ~mem_stall → exc_flush this cycle; go to RUN.
  - exc_M is ignored in this state (M is frozen).
- exc_redirect = exc_flush.
- The exception overrides mdu_busy: the MDU op is younger and is cancelled.

Outputs (x̄ denotes ~exc_flush):
- stallF = stallD = (mem_stall | mdu_busy | hz) & x̄.
- stallE = (mem_stall | mdu_busy) & x̄.
- stallM = stallW = mem_stall & x̄.
- flushF = 0.
- flushD = (branchE & predict_wrong & ~longest_stall) | exc_flush.
- flushE = (hz & ~longest_stall) | exc_flush.
- flushM = (mdu_busy & ~mem_stall) | exc_flush.
- flushW = exc_flush.

Perf counter:
- Increments when stallF=1.
- Saturates at 2^CNT_W-1.
- perf_clr has priority over increment.

## Timing
- All outputs are combinational from inputs and registered state; no added latency.
- The MDU op occupies E for exactly MDU_LAT cycles plus any mem_stall cycles.
- The deferred exception flushes in the first cycle that mem_stall=0.
- Reset values (async, resetn=0): state=RUN, cnt=0, stall_cycles=0.
  - With all inputs 0, every stall/flush output is 0 and forwards are 00.
- Reset mid-MDU or in EXC_WAIT aborts the op or the pending exception without a flush.

## Structure
- Shared package: state encoding (RUN=0, EXC_WAIT=1) and forward-select constants (FWD_RF=00, FWD_W=01, FWD_M=10).
- One natural sub-module: hazard_mdu_cnt, holding the occupancy counter with mdu_busy/mdu_done.
- FSM, forwarding and the perf counter stay in the top level.

## Test plan
- rsE=rtE=5, writeregM=5 (regwrite_enM=1), writeregW=5 (regwrite_enW=1) → forwardaE=forwardbE=10; then rsE=0 → forwardaE=00.
- memtoregE=1, rtE=3, rsD=3 → stallF=stallD=flushE=1 for one cycle; with d_stall=1 added → flushE=0, stallE=1.
- mdu_start_E held, MDU_LAT=4 → mdu_busy for 3 cycles with flushM=1, mdu_done on cycle 4; a 2-cycle d_stall mid-op extends the occupancy to 6 cycles.
- exc_M=1 with i_stall=1 for 3 cycles → no flush while stalled; the cycle i_stall drops gives exc_redirect=1 and flushD/E/M/W=1, then state returns to RUN.
- exc_M while the MDU is busy (cnt=2) → exc_flush the same cycle, cnt=0, stallE=0.
- 10 stallF cycles → stall_cycles=10; perf_clr and stallF asserted together → 0; with CNT_W=4 the counter saturates at 15.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared encodings for the hazard controller
package hazard_ctrl_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        EXC_WAIT = 1'b1
    } exc_state_t;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

endpackage

// File: rtl/hazard_mdu_cnt.sv
// rtl/hazard_mdu_cnt.sv - MDU occupancy counter holding a multi-cycle op in E
module hazard_mdu_cnt
    import hazard_ctrl_pkg::*;
#(
    parameter int MDU_LAT = 32
) (
    input  logic clk,
    input  logic resetn,
    input  logic mdu_start_E,
    input  logic mem_stall,
    input  logic exc_flush,
    output logic mdu_busy,
    output logic mdu_done
);

    localparam int CW = (MDU_LAT > 1) ? $clog2(MDU_LAT) : 1;
    localparam logic [CW-1:0] LAST = CW'(MDU_LAT - 1);

    logic [CW-1:0] cnt;

    assign mdu_busy = mdu_start_E & (cnt != LAST);
    assign mdu_done = mdu_start_E & (cnt == LAST);

    // A flushing exception cancels the younger MDU op; memory stalls freeze it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (exc_flush) begin
            cnt <= '0;
        end else if (mdu_start_E && !mem_stall) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard controller with MDU hold, deferred exception flush and stall counter
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_W   = 5,
    parameter int MDU_LAT = 32,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [REG_W-1:0] rsD,
    input  logic [REG_W-1:0] rtD,
    input  logic             branchD,
    input  logic             jumprD,
    input  logic [REG_W-1:0] rsE,
    input  logic [REG_W-1:0] rtE,
    input  logic [REG_W-1:0] writeregE,
    input  logic             regwrite_enE,
    input  logic             branchE,
    input  logic             predict_wrong,
    input  logic [1:0]       memtoregE,
    input  logic [1:0]       memtoregM,
    input  logic             mdu_start_E,
    input  logic [REG_W-1:0] writeregM,
    input  logic [REG_W-1:0] writeregW,
    input  logic             regwrite_enM,
    input  logic             regwrite_enW,
    input  logic             exc_M,
    input  logic             i_stall,
    input  logic             d_stall,
    input  logic             perf_clr,
    output logic             forwardaD,
    output logic             forwardbD,
    output logic [1:0]       forwardaE,
    output logic [1:0]       forwardbE,
    output logic             stallF,
    output logic             stallD,
    output logic             stallE,
    output logic             stallM,
    output logic             stallW,
    output logic             flushF,
    output logic             flushD,
    output logic             flushE,
    output logic             flushM,
    output logic             flushW,
    output logic             longest_stall,
    output logic             mdu_done,
    output logic             exc_redirect,
    output logic [CNT_W-1:0] stall_cycles
);

    logic       mem_stall, mdu_busy, exc_flush;
    logic       lw_hz, jr_hz, br_hz, hz;
    logic       e_hits_d, m_hits_d;
    exc_state_t state, state_next;

    assign mem_stall = i_stall | d_stall;

    assign forwardaD = (rsD != '0) & regwrite_enM & (rsD == writeregM);
    assign forwardbD = (rtD != '0) & regwrite_enM & (rtD == writeregM);

    always_comb begin
        forwardaE = FWD_RF;
        forwardbE = FWD_RF;
        if (rsE != '0 && regwrite_enM && rsE == writeregM)      forwardaE = FWD_M;
        else if (rsE != '0 && regwrite_enW && rsE == writeregW) forwardaE = FWD_W;
        if (rtE != '0 && regwrite_enM && rtE == writeregM)      forwardbE = FWD_M;
        else if (rtE != '0 && regwrite_enW && rtE == writeregW) forwardbE = FWD_W;
    end

    assign e_hits_d = (writeregE == rsD) | (writeregE == rtD);
    assign m_hits_d = (writeregM == rsD) | (writeregM == rtD);
    assign lw_hz    = (memtoregE != 2'b00) & ((rtE == rsD) | (rtE == rtD));
    assign jr_hz    = jumprD & regwrite_enE & e_hits_d;
    assign br_hz    = branchD & ((regwrite_enE & e_hits_d) | ((memtoregM != 2'b00) & m_hits_d));
    assign hz       = lw_hz | jr_hz | br_hz;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= RUN;
        else         state <= state_next;
    end

    // M is frozen while memory stalls, so a pending exception waits for release.
    always_comb begin
        state_next = state;
        exc_flush  = 1'b0;
        case (state)
            RUN: begin
                if (exc_M) begin
                    if (mem_stall) state_next = EXC_WAIT;
                    else           exc_flush  = 1'b1;
                end
            end
            EXC_WAIT: begin
                if (!mem_stall) begin
                    exc_flush  = 1'b1;
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

    hazard_mdu_cnt #(
        .MDU_LAT (MDU_LAT)
    ) u_mdu_cnt (
        .clk         (clk),
        .resetn      (resetn),
        .mdu_start_E (mdu_start_E),
        .mem_stall   (mem_stall),
        .exc_flush   (exc_flush),
        .mdu_busy    (mdu_busy),
        .mdu_done    (mdu_done)
    );

    assign longest_stall = mem_stall | mdu_busy;
    assign exc_redirect  = exc_flush;

    assign stallF = (mem_stall | mdu_busy | hz) & ~exc_flush;
    assign stallD = stallF;
    assign stallE = (mem_stall | mdu_busy) & ~exc_flush;
    assign stallM = mem_stall & ~exc_flush;
    assign stallW = stallM;

    assign flushF = 1'b0;
    assign flushD = (branchE & predict_wrong & ~longest_stall) | exc_flush;
    assign flushE = (hz & ~longest_stall) | exc_flush;
    assign flushM = (mdu_busy & ~mem_stall) | exc_flush;
    assign flushW = exc_flush;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_cycles <= '0;
        end else if (perf_clr) begin
            stall_cycles <= '0;
        end else if (stallF && stall_cycles != {CNT_W{1'b1}}) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

    localparam int REG_W   = 5;
    localparam int MDU_LAT = 4;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             resetn;
    logic [REG_W-1:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
    logic             branchD, jumprD, regwrite_enE, branchE, predict_wrong;
    logic [1:0]       memtoregE, memtoregM;
    logic             mdu_start_E, regwrite_enM, regwrite_enW, exc_M;
    logic             i_stall, d_stall, perf_clr;
    logic             forwardaD, forwardbD;
    logic [1:0]       forwardaE, forwardbE;
    logic             stallF, stallD, stallE, stallM, stallW;
    logic             flushF, flushD, flushE, flushM, flushW;
    logic             longest_stall, mdu_done, exc_redirect;
    logic [CNT_W-1:0] stall_cycles;

    hazard_ctrl #(.REG_W(REG_W), .MDU_LAT(MDU_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .resetn(resetn), .rsD(rsD), .rtD(rtD), .branchD(branchD), .jumprD(jumprD),
        .rsE(rsE), .rtE(rtE), .writeregE(writeregE), .regwrite_enE(regwrite_enE),
        .branchE(branchE), .predict_wrong(predict_wrong), .memtoregE(memtoregE),
        .memtoregM(memtoregM), .mdu_start_E(mdu_start_E), .writeregM(writeregM),
        .writeregW(writeregW), .regwrite_enM(regwrite_enM), .regwrite_enW(regwrite_enW),
        .exc_M(exc_M), .i_stall(i_stall), .d_stall(d_stall), .perf_clr(perf_clr),
        .forwardaD(forwardaD), .forwardbD(forwardbD), .forwardaE(forwardaE),
        .forwardbE(forwardbE), .stallF(stallF), .stallD(stallD), .stallE(stallE),
        .stallM(stallM), .stallW(stallW), .flushF(flushF), .flushD(flushD),
        .flushE(flushE), .flushM(flushM), .flushW(flushW), .longest_stall(longest_stall),
        .mdu_done(mdu_done), .exc_redirect(exc_redirect), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;
    bit run_chk = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: cycles the current MDU op has progressed, pending deferred exception, stall count.
    int m_prog = 0;
    bit m_pend = 1'b0;
    int m_perf = 0;

    function automatic bit f_mem();
        return i_stall || d_stall;
    endfunction
    function automatic bit f_exc();
        return m_pend ? !f_mem() : (exc_M && !f_mem());
    endfunction
    function automatic bit f_busy();
        return mdu_start_E && (m_prog < MDU_LAT - 1);
    endfunction
    function automatic bit f_hz();
        bit e_d, m_d;
        e_d = (writeregE == rsD) || (writeregE == rtD);
        m_d = (writeregM == rsD) || (writeregM == rtD);
        return (memtoregE != 0 && (rtE == rsD || rtE == rtD))
            || (jumprD && regwrite_enE && e_d)
            || (branchD && ((regwrite_enE && e_d) || (memtoregM != 0 && m_d)));
    endfunction
    function automatic bit f_stallF();
        return (f_mem() || f_busy() || f_hz()) && !f_exc();
    endfunction
    function automatic logic [1:0] f_fwd(input logic [REG_W-1:0] src);
        if (src != 0 && regwrite_enM && src == writeregM) return 2'b10;
        if (src != 0 && regwrite_enW && src == writeregW) return 2'b01;
        return 2'b00;
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_prog <= 0;
            m_pend <= 1'b0;
            m_perf <= 0;
        end else begin
            if (f_exc())                        m_prog <= 0;
            else if (mdu_start_E && !f_mem())   m_prog <= (m_prog + 1) % MDU_LAT;
            if (m_pend)                         m_pend <= f_mem();
            else if (exc_M && f_mem())          m_pend <= 1'b1;
            if (perf_clr)                       m_perf <= 0;
            else if (f_stallF())                m_perf <= (m_perf >= CNT_MAX) ? CNT_MAX : m_perf + 1;
        end
    end

    always @(negedge clk) begin : cmp
        bit mem, exc, busy, ls, hz, sf, se, sm;
        if (run_chk) begin
            mem  = f_mem();
            exc  = f_exc();
            busy = f_busy();
            hz   = f_hz();
            ls   = mem || busy;
            sf   = f_stallF();
            se   = ls && !exc;
            sm   = mem && !exc;
            chk("fwdD", 32'({forwardaD, forwardbD}),
                32'({rsD != 0 && regwrite_enM && rsD == writeregM,
                     rtD != 0 && regwrite_enM && rtD == writeregM}));
            chk("fwdE", 32'({forwardaE, forwardbE}), 32'({f_fwd(rsE), f_fwd(rtE)}));
            chk("stalls", 32'({stallF, stallD, stallE, stallM, stallW}), 32'({sf, sf, se, sm, sm}));
            chk("flushes", 32'({flushF, flushD, flushE, flushM, flushW}),
                32'({1'b0, (branchE && predict_wrong && !ls) || exc, (hz && !ls) || exc,
                     (busy && !mem) || exc, exc}));
            chk("misc", 32'({longest_stall, mdu_done, exc_redirect}),
                32'({ls, mdu_start_E && m_prog == MDU_LAT - 1, exc}));
            chk("stall_cycles", 32'(stall_cycles), 32'(m_perf));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic look();
        @(negedge clk);
        #1;
    endtask
    task automatic clr_in();
        rsD = '0; rtD = '0; rsE = '0; rtE = '0; writeregE = '0; writeregM = '0; writeregW = '0;
        branchD = 0; jumprD = 0; regwrite_enE = 0; branchE = 0; predict_wrong = 0;
        memtoregE = '0; memtoregM = '0; mdu_start_E = 0; regwrite_enM = 0; regwrite_enW = 0;
        exc_M = 0; i_stall = 0; d_stall = 0; perf_clr = 0;
    endtask

    initial begin
        clr_in();
        resetn  = 1'b0;
        run_chk = 1'b1;
        look();
        chk("rst_stalls", 32'({stallF, stallD, stallE, stallM, stallW}), 0);
        chk("rst_flushes", 32'({flushF, flushD, flushE, flushM, flushW}), 0);
        chk("rst_fwd", 32'({forwardaD, forwardbD, forwardaE, forwardbE}), 0);
        chk("rst_cnt", 32'(stall_cycles), 0);
        tick(); resetn = 1'b1;

        // forwarding: M over W, register 0 never forwarded
        tick(); rsE = 5; rtE = 5; writeregM = 5; regwrite_enM = 1; writeregW = 5; regwrite_enW = 1;
        look(); chk("fwd_mm", 32'({forwardaE, forwardbE}), 32'h0A);
        tick(); rsE = 0;
        look(); chk("fwd_r0", 32'({forwardaE, forwardbE}), 32'h02);
        tick(); regwrite_enM = 0;
        look(); chk("fwd_w", 32'(forwardbE), 1);
        tick(); clr_in(); rsD = 6; writeregM = 6; regwrite_enM = 1;
        look(); chk("fwd_d", 32'({forwardaD, forwardbD}), 32'h2);

        // load-use, then with memory stall
        tick(); clr_in(); memtoregE = 1; rtE = 3; rsD = 3;
        look(); chk("lw_hz", 32'({stallF, stallD, flushE, stallE}), 32'b1110);
        tick(); d_stall = 1;
        look(); chk("lw_mem", 32'({flushE, stallE}), 32'b01);

        // jr / branch hazards and mispredict
        tick(); clr_in(); jumprD = 1; regwrite_enE = 1; writeregE = 7; rsD = 7;
        look(); chk("jr_hz", 32'({stallF, flushE}), 32'b11);
        tick(); clr_in(); branchD = 1; memtoregM = 2; writeregM = 9; rtD = 9;
        look(); chk("br_hz", 32'(stallF), 1);
        tick(); clr_in(); branchE = 1; predict_wrong = 1;
        look(); chk("mispred", 32'(flushD), 1);
        tick(); i_stall = 1;
        look(); chk("mispred_stall", 32'(flushD), 0);

        // MDU op: 3 busy cycles then done
        tick(); clr_in(); mdu_start_E = 1;
        for (int i = 0; i < 4; i++) begin
            look(); chk("mdu_plain", 32'({mdu_done, flushM, stallE}), (i < 3) ? 32'b011 : 32'b100);
            tick();
        end
        // back-to-back op with a 2-cycle d_stall: occupies 6 cycles
        for (int i = 0; i < 6; i++) begin
            d_stall = (i == 2 || i == 3);
            look(); chk("mdu_stall_done", 32'(mdu_done), (i == 5) ? 1 : 0);
            tick();
        end
        clr_in();

        // deferred exception
        exc_M = 1; i_stall = 1;
        for (int i = 0; i < 3; i++) begin
            look(); chk("exc_wait", 32'({exc_redirect, flushD, flushE, flushM, flushW}), 0);
            tick();
        end
        i_stall = 0; exc_M = 0;
        look(); chk("exc_release", 32'({exc_redirect, flushD, flushE, flushM, flushW}), 32'h1F);
        tick();
        look(); chk("exc_run", 32'(exc_redirect), 0);

        // exception cancels a busy MDU op at cnt=2
        tick(); mdu_start_E = 1;
        tick(); tick(); exc_M = 1;
        look(); chk("exc_mdu", 32'({exc_redirect, stallE, flushM, stallF}), 32'b1010);
        tick(); exc_M = 0;
        for (int i = 0; i < 4; i++) begin
            look(); chk("mdu_restart", 32'(mdu_done), (i == 3) ? 1 : 0);
            tick();
        end
        clr_in();

        // perf counter: clear priority, count, saturate
        perf_clr = 1; i_stall = 1;
        tick(); perf_clr = 0;
        look(); chk("perf_clr", 32'(stall_cycles), 0);
        repeat (9) tick();
        tick(); i_stall = 0;
        look(); chk("perf_10", 32'(stall_cycles), 10);
        tick(); i_stall = 1; perf_clr = 1;
        tick(); perf_clr = 0;
        look(); chk("perf_clr2", 32'(stall_cycles), 0);
        repeat (20) tick();
        look(); chk("perf_sat", 32'(stall_cycles), 15);

        // reset while an exception is pending aborts it without a flush
        tick(); clr_in(); exc_M = 1; i_stall = 1;
        tick(); exc_M = 0;
        look(); chk("rst_pend_pre", 32'(exc_redirect), 0);
        resetn = 0; #1;
        chk("rst_async", 32'(stall_cycles), 0);
        i_stall = 0;
        tick(); resetn = 1;
        look(); chk("rst_pend_post", 32'(exc_redirect), 0);
        tick();

        run_chk = 1'b0;
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
